// File: rtl/cacheline_burst_adaptor.sv
// Bridges 256-bit cache line requests onto a 4-beat, 64-bit memory burst interface.
// One line transaction at a time; completion is a single-cycle pmem_resp pulse.
module cacheline_burst_adaptor #(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_line   = 256,
  parameter int unsigned s_burst  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pmem_read,
  input  logic                pmem_write,
  input  logic [31:0]         pmem_address,
  input  logic [s_line-1:0]   pmem_wdata,
  output logic [s_line-1:0]   pmem_rdata,
  output logic                pmem_resp,
  input  logic [s_burst-1:0]  burst_i,
  output logic [s_burst-1:0]  burst_o,
  output logic [31:0]         address_o,
  output logic                read_o,
  output logic                write_o,
  input  logic                resp_i
);

  localparam int unsigned num_beats = s_line / s_burst;
  localparam int unsigned CntW      = (num_beats > 1) ? $clog2(num_beats) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(num_beats - 1);
  localparam logic [31:0]     AddrMask = ~((32'd1 << s_offset) - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                              r_state;
  logic [CntW-1:0]                     r_cnt;
  logic [num_beats-1:0][s_burst-1:0]   r_rbuf;
  logic [num_beats-1:0][s_burst-1:0]   r_wbuf;
  logic [31:0]                         r_addr;
  logic                                r_read;
  logic                                r_write;
  logic                                r_resp;
  logic [31:0]                         w_line_addr;
  logic [s_burst-1:0]                  w_burst;

  assign w_line_addr = pmem_address & AddrMask;

  // Current write beat; held at zero outside WRITE so idle outputs stay quiet
  always_comb begin
    w_burst = '0;
    if (r_state == WRITE) begin
      w_burst = r_wbuf[r_cnt];
    end
  end

  // Separate read and write buffers so a write never disturbs pmem_rdata
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rbuf  <= '0;
      r_wbuf  <= '0;
      r_addr  <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_resp  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_resp <= 1'b0;
          r_cnt  <= '0;
          if (pmem_write) begin
            r_wbuf  <= pmem_wdata;
            r_addr  <= w_line_addr;
            r_write <= 1'b1;
            r_state <= WRITE;
          end else if (pmem_read) begin
            r_addr  <= w_line_addr;
            r_read  <= 1'b1;
            r_state <= READ;
          end
        end
        READ: begin
          if (resp_i) begin
            r_rbuf[r_cnt] <= burst_i;
            r_cnt         <= r_cnt + CntW'(1);
            if (r_cnt == LastBeat) begin
              r_read  <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            r_cnt <= r_cnt + CntW'(1);
            if (r_cnt == LastBeat) begin
              r_write <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_resp  <= 1'b0;
          r_read  <= 1'b0;
          r_write <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_read  <= 1'b0;
          r_write <= 1'b0;
          r_resp  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign pmem_rdata = r_rbuf;
  assign pmem_resp  = r_resp;
  assign burst_o    = w_burst;
  assign address_o  = r_addr;
  assign read_o     = r_read;
  assign write_o    = r_write;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed and randomized bench for cacheline_burst_adaptor against a line-level
// memory/requester model (expected lines, beat order, aligned address, pulse timing).
module tb_cacheline_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  cacheline_burst_adaptor dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .burst_i      (burst_i),
    .burst_o      (burst_o),
    .address_o    (address_o),
    .read_o       (read_o),
    .write_o      (write_o),
    .resp_i       (resp_i)
  );

  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [255:0] m_rdata;
  bit           pat[$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic bit pick_resp(input int mode);
    bit r;
    case (mode)
      0:       r = 1'b1;
      1:       r = (pat.size() > 0) ? pat.pop_front() : 1'b1;
      default: r = ($urandom_range(0, 2) != 0);
    endcase
    return r;
  endfunction

  // Full line read: mode 0 back-to-back beats, 1 scripted pattern, 2 random waits
  task automatic do_read(input logic [31:0] addr, input int mode, input bit fixed, input bit churn);
    logic [63:0]  beats[4];
    logic [255:0] line;
    logic [31:0]  exp_addr;
    int           got;
    int           cyc;
    bit           r;
    exp_addr = {addr[31:5], 5'b0};
    for (int i = 0; i < 4; i++) begin
      beats[i] = fixed ? 64'h1111_1111_1111_1111 * 64'(i + 1) : {$urandom, $urandom};
      line[64*i +: 64] = beats[i];
    end
    pmem_read = 1'b1; pmem_address = addr; resp_i = 1'b0;
    step();
    got = 0; cyc = 0;
    while (got < 4 && cyc < 64) begin
      check("rd_read_o", 256'(read_o), 256'(1));
      check("rd_write_o", 256'(write_o), 256'(0));
      check("rd_early_resp", 256'(pmem_resp), 256'(0));
      check("rd_addr", 256'(address_o), 256'(exp_addr));
      r = pick_resp(mode);
      resp_i  = r;
      burst_i = r ? beats[got] : {$urandom, $urandom};
      if (churn) begin
        pmem_address = $urandom;
        pmem_wdata   = rand256();
      end
      if (r) got++;
      step();
      cyc++;
    end
    resp_i = 1'b0; pmem_read = 1'b0;
    m_rdata = line;
    check("rd_resp", 256'(pmem_resp), 256'(1));
    check("rd_read_low", 256'(read_o), 256'(0));
    check("rd_rdata", pmem_rdata, m_rdata);
    check("rd_addr_done", 256'(address_o), 256'(exp_addr));
    step();
    check("rd_resp_once", 256'(pmem_resp), 256'(0));
    check("rd_rdata_hold", pmem_rdata, m_rdata);
  endtask

  // Full line write; both=1 also raises pmem_read to exercise write priority
  task automatic do_write(input logic [31:0] addr, input logic [255:0] wdata, input bit both,
                          input int mode, input bit churn);
    logic [31:0] exp_addr;
    int          got;
    int          cyc;
    bit          r;
    exp_addr = {addr[31:5], 5'b0};
    pmem_write = 1'b1; pmem_read = both; pmem_address = addr; pmem_wdata = wdata; resp_i = 1'b0;
    step();
    got = 0; cyc = 0;
    while (got < 4 && cyc < 64) begin
      check("wr_write_o", 256'(write_o), 256'(1));
      check("wr_read_o", 256'(read_o), 256'(0));
      check("wr_early_resp", 256'(pmem_resp), 256'(0));
      check("wr_addr", 256'(address_o), 256'(exp_addr));
      check("wr_burst", 256'(burst_o), 256'(wdata[64*got +: 64]));
      r = pick_resp(mode);
      resp_i  = r;
      burst_i = {$urandom, $urandom};
      if (churn) begin
        pmem_address = $urandom;
        pmem_wdata   = rand256();
      end
      if (r) got++;
      step();
      cyc++;
    end
    resp_i = 1'b0; pmem_write = 1'b0; pmem_read = 1'b0;
    check("wr_resp", 256'(pmem_resp), 256'(1));
    check("wr_write_low", 256'(write_o), 256'(0));
    check("wr_read_low", 256'(read_o), 256'(0));
    check("wr_rdata_kept", pmem_rdata, m_rdata);
    step();
    check("wr_resp_once", 256'(pmem_resp), 256'(0));
  endtask

  initial begin
    rst = 1'b1; pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0;
    pmem_wdata = '0; burst_i = '0; resp_i = 1'b0;
    m_rdata = '0;
    step();
    step();
    check("rst_resp", 256'(pmem_resp), 256'(0));
    check("rst_read_o", 256'(read_o), 256'(0));
    check("rst_write_o", 256'(write_o), 256'(0));
    check("rst_addr", 256'(address_o), 256'(0));
    check("rst_burst", 256'(burst_o), 256'(0));
    check("rst_rdata", pmem_rdata, 256'(0));
    rst = 1'b0;
    step();

    // Back-to-back read with fixed patterns
    do_read(32'h0000_1234, 0, 1'b1, 1'b0);
    check("rd_fixed_line", pmem_rdata,
          {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

    // Read with wait cycles 1,0,0,1,1,0,1
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    do_read(32'h0000_0ABC, 1, 1'b0, 1'b0);

    // Directed write
    do_write(32'h8000_003F,
             {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, 1'b0, 0, 1'b0);

    // Simultaneous requests: write wins, then a normal read
    do_write(32'h1234_5678, rand256(), 1'b1, 2, 1'b0);
    do_read(32'h0000_9990, 0, 1'b0, 1'b0);

    // Reset partway through a read
    pmem_read = 1'b1; pmem_address = 32'h0000_4040;
    step();
    for (int i = 0; i < 2; i++) begin
      resp_i = 1'b1; burst_i = {$urandom, $urandom};
      step();
    end
    check("rst_mid_pre_read_o", 256'(read_o), 256'(1));
    resp_i = 1'b0; rst = 1'b1; pmem_read = 1'b0;
    step();
    rst = 1'b0;
    m_rdata = '0;
    check("rst_mid_read_o", 256'(read_o), 256'(0));
    check("rst_mid_resp", 256'(pmem_resp), 256'(0));
    check("rst_mid_rdata", pmem_rdata, m_rdata);
    check("rst_mid_write_o", 256'(write_o), 256'(0));
    do_read(32'h0000_4040, 2, 1'b0, 1'b0);

    // Stray resp_i pulses while idle are ignored
    for (int i = 0; i < 3; i++) begin
      resp_i = 1'b1; burst_i = {$urandom, $urandom};
      step();
      check("stray_resp", 256'(pmem_resp), 256'(0));
      check("stray_read_o", 256'(read_o), 256'(0));
      check("stray_write_o", 256'(write_o), 256'(0));
      check("stray_rdata", pmem_rdata, m_rdata);
    end
    resp_i = 1'b0;

    // Back-to-back write then read with only the single idle cycle
    do_write(32'hCAFE_0011, rand256(), 1'b0, 0, 1'b0);
    do_read(32'hCAFE_0022, 0, 1'b0, 1'b0);

    // Randomized mix with waits and request churn after acceptance
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 0)
        do_write($urandom, rand256(), 1'(($urandom_range(0, 3)) == 0), 2, 1'b1);
      else
        do_read($urandom, 2, 1'b0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cacheline_burst_adaptor.md
Name: cacheline_burst_adaptor

Overview:
- Memory-side responder for the 256-bit line interface used by the instruction and data caches (pmem_read/pmem_write/pmem_address/pmem_rdata/pmem_wdata/pmem_resp).
- Services one whole-line request at a time by running a 4-beat, 64-bit burst transaction to physical memory (or the arbiter).
- Assembles read bursts into a 256-bit line and serialises write lines into bursts.
- Completes each request with a single-cycle pmem_resp.

Parameters:
- s_offset, 5, byte-offset bits of a line; pmem_address[s_offset-1:0] is forced to 0 on address_o.
- s_line, 256, line width in bits.
- s_burst, 64, beat width in bits.
- num_beats, s_line/s_burst (4), beats per line.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pmem_read  in  1  cache line read request; held until pmem_resp.
- pmem_write  in  1  cache line write request; held until pmem_resp.
- pmem_address  in  32  line address from cache.
- pmem_wdata  in  256  line to write.
- pmem_rdata  out  256  assembled read line.
- pmem_resp  out  1  one-cycle completion pulse.
- burst_i  in  64  read beat from memory.
- burst_o  out  64  write beat to memory.
- address_o  out  32  line-aligned address to memory.
- read_o  out  1  memory read burst request.
- write_o  out  1  memory write burst request.
- resp_i  in  1  memory beat valid/accepted strobe.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; beat counter 0; line buffer 0.
  - rst in any state aborts the transaction; the next cycle is IDLE with all outputs 0.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - If pmem_write: latch pmem_wdata into the line buffer, latch address, counter=0, go to WRITE.
  - Else if pmem_read: latch address, counter=0, go to READ.
  - Write has priority when both requests are high; this case is illegal from a single cache but tolerated.
  - pmem_resp=0, read_o=0, write_o=0.
- Address latch: address_o = {pmem_address[31:s_offset], s_offset'b0}, registered at acceptance and stable for the whole transaction.
- READ:
  - read_o=1.
  - Each cycle with resp_i=1: line_buf[s_burst*cnt +: s_burst] <= burst_i, cnt++.
  - Beats need not be consecutive; cycles with resp_i=0 are waits.
  - On the cycle capturing beat num_beats-1, go to DONE.
  - read_o deasserts in DONE.
- WRITE:
  - write_o=1; burst_o = line_buf[s_burst*cnt +: s_burst] (combinational from the counter).
  - Each cycle with resp_i=1, memory has accepted the current beat: cnt++.
  - After beat num_beats-1 is accepted, go to DONE.
- DONE:
  - pmem_resp=1 for exactly one cycle; read_o=write_o=0; next state IDLE.
- Latency:
  - Read with 4 back-to-back beats: request seen in cycle 0, read_o high cycles 1-4, pmem_resp in cycle 5.
  - Write: same timing.
- pmem_rdata:
  - Driven from the line buffer, valid in the DONE cycle.
  - Holds its value until the next read captures beats.
  - A write transaction does not change pmem_rdata; a separate read register is used, or the write path does not overwrite the read line.
- Requester contract:
  - Deassert the request in the cycle after pmem_resp.
  - A request still high in the IDLE cycle after DONE is treated as new.
- Request changes:
  - Changes to pmem_address or pmem_wdata after acceptance are ignored.
  - Deassertion of the request mid-transaction is ignored; the burst completes.
- Counter width is clog2(num_beats) and wraps to 0 at completion.
- resp_i while in IDLE or DONE is ignored.

Test Plan:
- Read, back-to-back beats:
  - Stimulus: pmem_read=1, pmem_address=0x0000_1234; memory supplies 0x1111..., 0x2222..., 0x3333..., 0x4444... (64-bit patterns) on consecutive resp_i.
  - Required: address_o=0x0000_1220; pmem_resp pulses once, 5 cycles after the request; pmem_rdata = {0x4444...,0x3333...,0x2222...,0x1111...}.
- Read with waits:
  - Stimulus: resp_i pattern 1,0,0,1,1,0,1.
  - Required: beats land in slots 0-3 in order; pmem_resp occurs one cycle after the last beat; read_o stays high throughout.
- Write:
  - Stimulus: pmem_wdata = 256'hDDDD...CCCC...BBBB...AAAA..., address 0x8000_003F.
  - Required: address_o=0x8000_0020; burst_o = AAAA, BBBB, CCCC, DDDD on the 4 resp_i cycles; write_o drops; one pmem_resp pulse.
- Simultaneous requests:
  - Stimulus: pmem_read and pmem_write both high in IDLE.
  - Required: WRITE is executed, read_o stays 0.
  - Then: a read issued next completes normally.
- Reset mid-read:
  - Stimulus: assert rst after 2 beats.
  - Required: the next cycle has read_o=0, pmem_resp=0, pmem_rdata=0, state IDLE.
  - Then: a fresh read completes with correct data.
- Back-to-back requests and stray responses:
  - Stimulus: write then read with no idle gap beyond the required one cycle; resp_i pulses injected while in IDLE.
  - Required: both requests complete, each with exactly one pmem_resp; the stray pulses are ignored.
